sram_wb_wrapper: RTL and testbench

Wishbone B4 classic slave wrapping a 2048 x 32-bit single-port SRAM (8 KB) with per-byte write enables. It sits behind the wishbone decoder on the SRAM slot (system base 0x3300_0000); the decoder forwards the full 32-bit address. The arbitrator and manager reach it through the shared bus. Reads return only the selected byte lanes; unselected lanes read as zero.

---
 rtl/sram_wb_wrapper.sv | 77 +++++++
 tb/tb_sram_wb_wrapper.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sram_wb_wrapper.sv
// Wishbone B4 classic slave in front of a single-port word SRAM with byte-lane writes.
// One wait state per transfer; read data is lane-masked by the sel sampled at the request edge.
module sram_wb_wrapper #(
    parameter int unsigned NUM_WORDS = 2048
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [NUM_WORDS];
    logic              r_ack;
    logic [DATA_W-1:0] r_dat;

    logic              w_req;
    logic              w_wr;
    logic              w_rd;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_lane_mask;
    logic [DATA_W-1:0] w_rd_word;

    // Byte offset and bits above the SRAM region are don't-cares; the decoder owns the range.
    logic w_unused_adr;
    assign w_unused_adr = ^{wbs_adr_i[31:IDX_W+2], wbs_adr_i[1:0]};

    // The ~ack term blocks a duplicate access while stb/cyc are held through the ack cycle.
    assign w_req = wbs_stb_i & wbs_cyc_i & ~r_ack & ~wb_rst_i;
    assign w_wr  = w_req & wbs_we_i;
    assign w_rd  = w_req & ~wbs_we_i;
    assign w_idx = wbs_adr_i[IDX_W+1:2];

    always_comb begin
        w_lane_mask = '0;
        for (int n = 0; n < LANES; n++) begin
            w_lane_mask[8*n +: 8] = {8{wbs_sel_i[n]}};
        end
    end

    assign w_rd_word = r_mem[w_idx] & w_lane_mask;

    // Storage array: never reset, so contents survive wb_rst_i.
    always_ff @(posedge wb_clk_i) begin
        if (w_wr) begin
            for (int n = 0; n < LANES; n++) begin
                if (wbs_sel_i[n]) begin
                    r_mem[w_idx][8*n +: 8] <= wbs_dat_i[8*n +: 8];
                end
            end
        end
    end

    // Ack pulse and read-data register; data is zero outside a read ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rd_word : '0;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_sram_wb_wrapper.sv
// Directed self-checking bench for sram_wb_wrapper with hand-computed expected values.
module tb_sram_wb_wrapper;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] adr;
    logic        ack;
    logic [31:0] dat_o;

    int n_checks = 0;
    int n_errors = 0;

    sram_wb_wrapper #(.NUM_WORDS(2048)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;
    endtask

    // One transfer started just after a rising edge; ack expected exactly one edge later.
    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, output logic [31:0] rdat);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        chk("ack_before_req", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("ack_latency", 32'(ack), 32'd1);
        rdat = dat_o;
        if (w) chk("wr_ack_dat_zero", dat_o, 32'h0);
        idle_bus();
        @(posedge clk); #1;
        chk("ack_one_cycle", 32'(ack), 32'd0);
        chk("dat_zero_no_ack", dat_o, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] unused_rd;
        bus_xfer(1'b1, a, s, d, unused_rd);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] exp);
        logic [31:0] r;
        bus_xfer(1'b0, a, s, 32'h0, r);
        chk(tag, r, exp);
    endtask

    initial begin
        idle_bus();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_dat", dat_o, 32'h0);
        rst = 1'b0;

        wr(32'h3300_0000, 4'b1111, 32'h1234_5678);
        rd("full_word", 32'h3300_0000, 4'b1111, 32'h1234_5678);

        wr(32'h3300_0000, 4'b0001, 32'hAAAA_AAAA);
        rd("byte0_sel0001", 32'h3300_0000, 4'b0001, 32'h0000_00AA);
        rd("byte0_sel1111", 32'h3300_0000, 4'b1111, 32'h1234_56AA);

        wr(32'h3300_0000, 4'b0100, 32'hBBBB_BBBB);
        rd("byte2_sel0100", 32'h3300_0000, 4'b0100, 32'h00BB_0000);
        rd("byte2_sel1111", 32'h3300_0000, 4'b1111, 32'h12BB_56AA);

        wr(32'h3300_1FFF, 4'b1111, 32'h2233_4455);
        rd("last_word_1fff", 32'h3300_1FFF, 4'b1111, 32'h2233_4455);
        rd("last_word_1ffc", 32'h3300_1FFC, 4'b1111, 32'h2233_4455);
        rd("last_word_sel1010", 32'h3300_1FFE, 4'b1010, 32'h2200_4400);
        rd("word0_untouched", 32'h3300_0000, 4'b1111, 32'h12BB_56AA);
        rd("alias_upper_bits", 32'h0000_2000, 4'b1111, 32'h12BB_56AA);

        // Held strobe: acks must alternate, never two in a row.
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3300_0000; sel = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("held_ack_%0d", i), 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("held_dat_%0d", i), dat_o, (i % 2 == 0) ? 32'h12BB_56AA : 32'h0);
        end
        idle_bus();
        @(posedge clk); #1;

        // Request presented while in reset must be discarded.
        wr(32'h3300_0014, 4'b1111, 32'h5555_5555);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3300_0014; sel = 4'b1111;
        dat_i = 32'hDEAD_BEEF;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_ack_%0d", i), 32'(ack), 32'd0);
            chk($sformatf("rst_dat_%0d", i), dat_o, 32'h0);
        end
        rst = 1'b0;
        idle_bus();
        @(posedge clk); #1;
        chk("post_rst_ack", 32'(ack), 32'd0);
        rd("rst_write_discarded", 32'h3300_0014, 4'b1111, 32'h5555_5555);
        rd("mem_survives_rst", 32'h3300_0000, 4'b1111, 32'h12BB_56AA);

        // Reset landing in the ack cycle kills the ack but keeps the committed write.
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3300_0018; sel = 4'b1111;
        dat_i = 32'h6666_6666;
        @(posedge clk); #1;
        chk("ack_before_rst", 32'(ack), 32'd1);
        idle_bus();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ack_ack", 32'(ack), 32'd0);
        chk("rst_in_ack_dat", dat_o, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        rd("write_kept_after_rst", 32'h3300_0018, 4'b1111, 32'h6666_6666);

        wr(32'h3300_0000, 4'b0000, 32'hFFFF_FFFF);
        rd("sel0000_no_change", 32'h3300_0000, 4'b1111, 32'h12BB_56AA);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
